piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
Parallel-in serial-out transmitter: accepts a SIZE-bit configuration word through a valid/ready handshake and shifts it out LSB-first on one serial line, with a framing strobe held high for exactly the data bits. It is the sending end of the serial configuration link. Its data_out/start_data pair drives the link receiver's data/Start_data inputs directly.

Parameters:
SIZE, 35, width of parallel word and number of data bits per frame (legal range 2..63)
GAP, 1, idle cycles (start_data low) forced after each frame before next load is accepted (legal range 1..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset)
par_in  input  SIZE  word to transmit; sampled only on accept
load_valid  input  1  par_in is valid
load_ready  output  1  transmitter can accept a word this cycle
data_out  output  1  serial data, LSB first
start_data  output  1  frame strobe; high for each cycle data_out carries a frame bit
busy  output  1  high from accept cycle+1 until end of gap
tx_done  output  1  one-cycle pulse after final frame bit

Behaviour:
- Reset (rst=0, async assert, sync deassert by design): state=IDLE, shift reg=0, bit counter=0, gap counter=0; data_out=0, start_data=0, busy=0, tx_done=0, load_ready=1 after deassert.
- States: IDLE, SHIFT, GAP.
- IDLE: load_ready=1. Accept when load_valid && load_ready at edge k: shift reg <= par_in, counter <= 0, go SHIFT.
- SHIFT: registered outputs; edge k+1 onward start_data=1 and data_out=par_in[i] during cycle k+1+i, i=0..SIZE-1. Shift right each cycle; counter increments. Leaving after bit SIZE-1 -> GAP.
- Latency: first bit visible in cycle after accept; frame occupies exactly SIZE consecutive cycles, no bubbles.
- GAP: start_data=0, data_out=0, busy=1, GAP cycles; tx_done=1 in first GAP cycle only. After GAP cycles -> IDLE.
- load_ready=0 in SHIFT and GAP; load_valid ignored there (no queuing); par_in changes mid-frame have no effect.
- Back-to-back: load_valid held high gives frames separated by exactly GAP+1 low-strobe cycles (GAP plus IDLE accept cycle).
- Counter width $clog2(SIZE+1); terminal compare at SIZE-1, no wrap.
- Reset mid-frame: outputs drop to reset values immediately (async), frame abandoned; no tx_done.
- data_out forced 0 whenever start_data=0.

Optional Feature:
Macro PISO_TX_PARITY_EN.
- Defined: after bit SIZE-1 one extra bit, even parity (XOR of par_in), is sent with start_data=1; frame length SIZE+1; tx_done in cycle after parity bit. Receiver must be sized SIZE+1.
- Undefined: frame is SIZE bits, no parity logic present.

Decomposition:
- Shared package: state enum (IDLE/SHIFT/GAP), default CFG_WORD_SIZE=35, CFG_GAP_MIN=1, counter width function.
- No sub-module required; optional piso_tx_parity helper (XOR reduce) only under PISO_TX_PARITY_EN, else single module.

Test Plan:
- Reset: rst=0 mid-SHIFT after bit 10 -> start_data, data_out, busy, tx_done =0 same cycle; load_ready=1 after release; no tx_done.
- Single frame SIZE=35, par_in=35'h5_A5A5_A5A5 -> start_data high 35 cycles starting cycle after accept; serialized bits reassemble to 35'h5_A5A5_A5A5; tx_done one pulse in cycle 36.
- Back-to-back, load_valid held, words 35'h0_0000_0001 then 35'h4_0000_0000 -> first frame bit0=1 rest 0, gap of 2 low cycles (GAP=1), second frame bit34=1 only; load_ready high only in IDLE accept cycles.
- Loopback with link receiver (SIZE=35, GAP=1), 100 random words -> receiver parallel output equals each par_in, one load_data per frame.
- Handshake: load_valid pulsed during SHIFT and GAP -> ignored, no frame generated; par_in toggled mid-frame -> transmitted bits unchanged.
- PISO_TX_PARITY_EN, par_in=35'h0_0000_0007 -> 36 strobe cycles, bit 35=1; par_in=35'h0_0000_0003 -> bit 35=0.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared constants for the serial configuration transmitter.
// Contents: default word size and gap, FSM state encodings, counter width helper.
package piso_tx_pkg;

    localparam int unsigned CFG_WORD_SIZE = 35;
    localparam int unsigned CFG_GAP_MIN   = 1;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [ST_W-1:0] ST_GAP   = 2'd2;

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake and serial link bundle for piso_tx.
// master: drives par_in/load_valid, observes everything else.
// slave : the transmitter; drives load_ready, data_out, start_data, busy, tx_done.
interface piso_tx_if
    import piso_tx_pkg::*;
#(
    parameter int unsigned SIZE = CFG_WORD_SIZE
);
    logic [SIZE-1:0] par_in;
    logic            load_valid;
    logic            load_ready;
    logic            data_out;
    logic            start_data;
    logic            busy;
    logic            tx_done;

    modport master (
        output par_in, load_valid,
        input  load_ready, data_out, start_data, busy, tx_done
    );

    modport slave (
        input  par_in, load_valid,
        output load_ready, data_out, start_data, busy, tx_done
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter for the serial configuration link.
// Accepts a SIZE-bit word on a valid/ready handshake and sends it LSB first
// with start_data framing the data bits, then holds the line idle for GAP cycles.
// Ports: clk, rst (async active-low), bus (piso_tx_if.slave).
// Build option: PISO_TX_PARITY_EN appends an even-parity bit to each frame.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned SIZE = CFG_WORD_SIZE,
    parameter int unsigned GAP  = CFG_GAP_MIN
) (
    input  logic       clk,
    input  logic       rst,
    piso_tx_if.slave   bus
);

`ifdef PISO_TX_PARITY_EN
    localparam int unsigned LAST = SIZE;
`else
    localparam int unsigned LAST = SIZE - 1;
`endif
    localparam int unsigned CW = cnt_width(SIZE);
    localparam int unsigned GW = cnt_width(GAP);

    logic [ST_W-1:0] state,     state_nxt;
    logic [SIZE-1:0] shift_reg, shift_nxt;
    logic [CW-1:0]   bit_cnt,   bit_cnt_nxt;
    logic [GW-1:0]   gap_cnt,   gap_cnt_nxt;
    logic            data_q,    data_nxt;
    logic            start_q,   start_nxt;
    logic            busy_q,    busy_nxt;
    logic            done_q,    done_nxt;
    logic            ready_q,   ready_nxt;
`ifdef PISO_TX_PARITY_EN
    logic            parity_q,  parity_nxt;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            data_q    <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef PISO_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            data_q    <= data_nxt;
            start_q   <= start_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            ready_q   <= ready_nxt;
`ifdef PISO_TX_PARITY_EN
            parity_q  <= parity_nxt;
`endif
        end
    end

    // Next-state logic; data/strobe default low so data_out is 0 outside a frame.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        data_nxt    = 1'b0;
        start_nxt   = 1'b0;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        ready_nxt   = ready_q;
`ifdef PISO_TX_PARITY_EN
        parity_nxt  = parity_q;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.load_valid && ready_q) begin
                    // Bit 0 goes straight to the line; the rest waits in shift_reg.
                    state_nxt   = ST_SHIFT;
                    shift_nxt   = bus.par_in >> 1;
                    bit_cnt_nxt = '0;
                    data_nxt    = bus.par_in[0];
                    start_nxt   = 1'b1;
                    busy_nxt    = 1'b1;
                    ready_nxt   = 1'b0;
`ifdef PISO_TX_PARITY_EN
                    parity_nxt  = ^bus.par_in;
`endif
                end
            end
            ST_SHIFT: begin
                // bit_cnt is the index of the bit currently on the line.
                if (bit_cnt == CW'(LAST)) begin
                    state_nxt   = ST_GAP;
                    gap_cnt_nxt = '0;
                    done_nxt    = 1'b1;
                end else begin
                    bit_cnt_nxt = bit_cnt + CW'(1);
                    start_nxt   = 1'b1;
                    shift_nxt   = shift_reg >> 1;
`ifdef PISO_TX_PARITY_EN
                    data_nxt    = (bit_cnt == CW'(SIZE - 1)) ? parity_q : shift_reg[0];
`else
                    data_nxt    = shift_reg[0];
`endif
                end
            end
            ST_GAP: begin
                if (gap_cnt == GW'(GAP - 1)) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
            end
        endcase
    end

    assign bus.data_out   = data_q;
    assign bus.start_data = start_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.load_ready = ready_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (SIZE=35, GAP=1).
// Drives and samples 1 time unit after each rising edge.
module tb_piso_tx;

    localparam int unsigned SIZE = 35;
    localparam int unsigned GAP  = 1;
`ifdef PISO_TX_PARITY_EN
    localparam int unsigned FL = SIZE + 1;
`else
    localparam int unsigned FL = SIZE;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    piso_tx_if #(.SIZE(SIZE)) bus ();

    piso_tx #(.SIZE(SIZE), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Collect FL bits starting with the one currently on the line.
    task automatic capture(input bit disturb, output logic [63:0] word, output int bad);
        word = '0;
        bad  = 0;
        for (int i = 0; i < int'(FL); i++) begin
            if (!bus.start_data) bad++;
            if (bus.load_ready)  bad++;
            if (!bus.busy)       bad++;
            if (bus.tx_done)     bad++;
            word[i] = bus.data_out;
            if (disturb) begin
                bus.par_in     = ~bus.par_in;
                bus.load_valid = (i % 2) == 1;
            end
            tick();
        end
    endtask

    // One isolated frame with par_in/load_valid disturbed mid-frame and during the gap.
    task automatic send_frame(input logic [SIZE-1:0] w, input logic [63:0] exp, input string tag);
        logic [63:0] got;
        int          bad;
        check({tag, "_ready_idle"}, 64'(bus.load_ready), 64'd1);
        bus.par_in     = w;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        check({tag, "_first_strobe"}, 64'(bus.start_data), 64'd1);
        capture(1'b1, got, bad);
        bus.load_valid = 1'b0;
        check({tag, "_frame_flags"}, 64'(bad), 64'd0);
        check({tag, "_data"}, got, exp);
        check({tag, "_done"}, 64'(bus.tx_done), 64'd1);
        check({tag, "_gap_strobe"}, {62'd0, bus.start_data, bus.data_out}, 64'd0);
        check({tag, "_gap_busy"}, 64'(bus.busy), 64'd1);
        bus.load_valid = 1'b1;
        for (int g = 1; g < int'(GAP); g++) begin
            tick();
            check({tag, "_done_once"}, 64'(bus.tx_done), 64'd0);
        end
        tick();
        bus.load_valid = 1'b0;
        check({tag, "_idle_flags"}, {62'd0, bus.busy, bus.load_ready}, 64'd1);
        bad = 0;
        repeat (3) begin
            tick();
            if (bus.start_data || bus.tx_done) bad++;
        end
        check({tag, "_no_extra_frame"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [63:0]     got;
        logic [SIZE-1:0] w;
        int              bad;
        int              n;
        int              r;

        rst            = 1'b0;
        bus.par_in     = '0;
        bus.load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {60'd0, bus.start_data, bus.data_out, bus.busy, bus.tx_done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("reset_release_ready", 64'(bus.load_ready), 64'd1);
        check("reset_release_busy", 64'(bus.busy), 64'd0);

`ifdef PISO_TX_PARITY_EN
        send_frame(35'h5_A5A5_A5A5, 64'h5_A5A5_A5A5, "a5");
        send_frame(35'h7_FFFF_FFFF, 64'hF_FFFF_FFFF, "ones");
        send_frame(35'h0_0000_0007, 64'h8_0000_0007, "par7");
        send_frame(35'h0_0000_0003, 64'h0_0000_0003, "par3");
`else
        send_frame(35'h5_A5A5_A5A5, 64'h5_A5A5_A5A5, "a5");
        send_frame(35'h7_FFFF_FFFF, 64'h7_FFFF_FFFF, "ones");
        send_frame(35'h0_0000_0007, 64'h0_0000_0007, "w7");
        send_frame(35'h2_AAAA_5555, 64'h2_AAAA_5555, "aa55");
`endif

        // Back-to-back with load_valid held high.
        bus.par_in     = 35'h0_0000_0001;
        bus.load_valid = 1'b1;
        tick();
        bus.par_in = 35'h4_0000_0000;
        capture(1'b0, got, bad);
`ifdef PISO_TX_PARITY_EN
        check("b2b_first_data", got, 64'h8_0000_0001);
`else
        check("b2b_first_data", got, 64'h0_0000_0001);
`endif
        check("b2b_first_flags", 64'(bad), 64'd0);
        n = 0;
        r = 0;
        while (!bus.start_data && n < 20) begin
            n++;
            if (bus.load_ready) r++;
            tick();
        end
        check("b2b_gap_len", 64'(n), 64'(GAP + 1));
        check("b2b_ready_cycles", 64'(r), 64'd1);
        bus.load_valid = 1'b0;
        capture(1'b0, got, bad);
`ifdef PISO_TX_PARITY_EN
        check("b2b_second_data", got, 64'hC_0000_0000);
`else
        check("b2b_second_data", got, 64'h4_0000_0000);
`endif
        check("b2b_second_flags", 64'(bad), 64'd0);
        check("b2b_second_done", 64'(bus.tx_done), 64'd1);
        repeat (GAP) tick();
        check("b2b_back_idle", 64'(bus.load_ready), 64'd1);

        // Reset in the middle of a frame.
        w              = 35'h5_A5A5_A5A5;
        bus.par_in     = w;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        repeat (10) tick();
        check("mid_bit10", 64'(bus.data_out), 64'(w[10]));
        check("mid_strobe", 64'(bus.start_data), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", {60'd0, bus.start_data, bus.data_out, bus.busy, bus.tx_done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("mid_reset_ready", 64'(bus.load_ready), 64'd1);
        bad = 0;
        repeat (FL + 5) begin
            if (bus.tx_done || bus.start_data || bus.busy) bad++;
            tick();
        end
        check("mid_reset_abandoned", 64'(bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
